// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared types and constants for the UART slice.
//   rx_state_t : receiver FSM states
//   UART_OVS   : oversampling factor (ticks per bit)
//   UART_DATA_BITS : data bits per frame
//   ovs_div()  : system clocks per oversampling tick (integer truncation)
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int UART_OVS       = 16;
  localparam int UART_DATA_BITS = 8;

  function automatic int ovs_div(input int unsigned clk_hz, input int unsigned baud);
    return int'(clk_hz / (baud * UART_OVS));
  endfunction

endpackage

// File: rtl/wrap_around_fifo.sv
// wrap_around_fifo
//   Synchronous FIFO with wrap-around pointers carrying one extra wrap bit.
//   Head word is presented combinationally (first-word fall-through).
// Ports
//   clk_i   in   clock
//   rst_ni  in   asynchronous active-low reset, flushes the FIFO
//   wr_en_i in   push din_i (ignored when full)
//   din_i   in   write data
//   rd_en_i in   pop head (ignored when empty)
//   dout_o  out  head data, 0 while empty
//   empty_o out  FIFO empty
//   full_o  out  FIFO full
module wrap_around_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  // Same address with differing wrap bits means the writer lapped the reader.
  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign do_push = wr_en_i && !full_o;
  assign do_pop  = rd_en_i && !empty_o;

  // Storage is not reset; an empty FIFO forces the head to zero instead.
  assign dout_o = empty_o ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= din_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx
//   UART receiver, 8N1, LSB first, 16x oversampling. Synchronises the line,
//   validates the start bit, samples each bit at its centre, checks the stop
//   bit and pushes good bytes into a receive FIFO drained by rd_en_i.
// Ports
//   clk_i       in   system clock
//   rst_ni      in   asynchronous active-low reset
//   rx_en_i     in   receive enable; dropping it aborts a frame in progress
//   rx_bit_i    in   asynchronous serial line, idle high
//   rd_en_i     in   pop FIFO head (ignored when empty)
//   dout_o      out  FIFO head data, valid while empty_o=0
//   empty_o     out  FIFO empty
//   full_o      out  FIFO full
//   frame_err_o out  1-cycle pulse: stop bit sampled low
//   overrun_o   out  1-cycle pulse: good byte dropped, FIFO full
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_en_i,
  input  logic                  rx_bit_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  frame_err_o,
  output logic                  overrun_o
);

  localparam int OVS_DIV = ovs_div(CLK_FREQ, BAUD_RATE);
  localparam int TICK_W  = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;

  localparam logic [3:0] SAMPLE_MID  = 4'(UART_OVS / 2 - 1);
  localparam logic [3:0] SAMPLE_LAST = 4'(UART_OVS - 1);
  localparam logic [2:0] BIT_LAST    = 3'(UART_DATA_BITS - 1);

  rx_state_t                 state;
  logic [1:0]                sync_q;
  logic                      rx_s;
  logic [TICK_W-1:0]         tick_cnt;
  logic                      tick;
  logic [3:0]                sample_cnt;
  logic [2:0]                bit_cnt;
  logic [UART_DATA_BITS-1:0] shreg;
  logic                      wr_en;
  logic [DATA_WIDTH-1:0]     fifo_din;

  // Two-flop synchroniser; resets to the idle-high line level so reset
  // release never looks like a start bit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_bit_i};
    end
  end

  assign rx_s = sync_q[1];

  // Oversampling tick. Held at zero in IDLE, which also clears it on the
  // IDLE->START transition, so the first tick lands OVS_DIV cycles later.
  assign tick = (state != IDLE) && (tick_cnt == TICK_W'(OVS_DIV - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_cnt <= '0;
    end else if (state == IDLE || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Receiver FSM. A disable in any active state wins over sampling events.
  // The start bit is checked at its centre (8th tick); from then on every
  // 16th tick lands at a bit centre. Stop-bit failure is reported before
  // overrun, and the push is registered so wr_en is a clean 1-cycle strobe.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      sample_cnt  <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      wr_en       <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      wr_en       <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
      if (state != IDLE && !rx_en_i) begin
        state      <= IDLE;
        sample_cnt <= '0;
        bit_cnt    <= '0;
        shreg      <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rx_en_i && !rx_s) begin
              state      <= START;
              sample_cnt <= '0;
              bit_cnt    <= '0;
            end
          end
          START: begin
            if (tick) begin
              if (sample_cnt == SAMPLE_MID) begin
                sample_cnt <= '0;
                bit_cnt    <= '0;
                state      <= rx_s ? IDLE : DATA;
              end else begin
                sample_cnt <= sample_cnt + 1'b1;
              end
            end
          end
          DATA: begin
            if (tick) begin
              if (sample_cnt == SAMPLE_LAST) begin
                sample_cnt <= '0;
                shreg      <= {rx_s, shreg[UART_DATA_BITS-1:1]};
                if (bit_cnt == BIT_LAST) begin
                  state <= STOP;
                end else begin
                  bit_cnt <= bit_cnt + 1'b1;
                end
              end else begin
                sample_cnt <= sample_cnt + 1'b1;
              end
            end
          end
          STOP: begin
            if (tick) begin
              if (sample_cnt == SAMPLE_LAST) begin
                sample_cnt <= '0;
                state      <= IDLE;
                if (!rx_s) begin
                  frame_err_o <= 1'b1;
                end else if (full_o) begin
                  overrun_o <= 1'b1;
                end else begin
                  wr_en <= 1'b1;
                end
              end else begin
                sample_cnt <= sample_cnt + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign fifo_din = DATA_WIDTH'(shreg);

  wrap_around_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .wr_en_i(wr_en),
    .din_i  (fifo_din),
    .rd_en_i(rd_en_i),
    .dout_o (dout_o),
    .empty_o(empty_o),
    .full_o (full_o)
  );

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
//   Directed bench for uart_rx with a scoreboard. Frames are driven bit by
//   bit; expected bytes and flag pulses are queued when a frame is issued and
//   a monitor compares them whenever the host pops the FIFO or a flag fires.
//   The receiver runs at 5 clocks per tick (10 MHz / (115200*16) = 5.42,
//   truncated), i.e. 80 clocks per bit, to keep the run short.
module tb_uart_rx;

  localparam int CLK_FREQ  = 10_000_000;
  localparam int BAUD_RATE = 115_200;
  localparam int BIT_CLKS  = 80;

  typedef enum {EXP_NONE, EXP_BYTE, EXP_FRAME_ERR, EXP_OVERRUN} exp_kind_t;

  logic       clk_i;
  logic       rst_ni;
  logic       rx_en_i;
  logic       rx_bit_i;
  logic       rd_en_i;
  logic [7:0] dout_o;
  logic       empty_o;
  logic       full_o;
  logic       frame_err_o;
  logic       overrun_o;

  int checks;
  int failures;
  int exp_frame_err;
  int exp_overrun;
  int frame_err_seen;
  int overrun_seen;
  logic [7:0] exp_q[$];

  uart_rx #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .DATA_WIDTH(8),
    .FIFO_DEPTH(16)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .rx_en_i    (rx_en_i),
    .rx_bit_i   (rx_bit_i),
    .rd_en_i    (rd_en_i),
    .dout_o     (dout_o),
    .empty_o    (empty_o),
    .full_o     (full_o),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Monitor: every accepted pop is compared against the scoreboard head;
  // flag pulses are counted per high cycle so a stretched pulse shows up.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (rd_en_i && !empty_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("[TB] FAIL pop_unexpected: got 0x%02h, required no data", dout_o);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (dout_o !== e) begin
            failures++;
            $display("[TB] FAIL pop_data: got 0x%02h, required 0x%02h", dout_o, e);
          end
        end
      end
      if (frame_err_o) frame_err_seen++;
      if (overrun_o) overrun_seen++;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: time limit reached before the end of the test sequence");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic sendFrame(input logic [7:0] data, input logic stop_bit);
    rx_bit_i = 1'b0;
    tick(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rx_bit_i = data[i];
      tick(BIT_CLKS);
    end
    rx_bit_i = stop_bit;
    tick(BIT_CLKS);
    rx_bit_i = 1'b1;
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input exp_kind_t kind);
    case (kind)
      EXP_BYTE:      exp_q.push_back(data);
      EXP_FRAME_ERR: exp_frame_err++;
      EXP_OVERRUN:   exp_overrun++;
      default:       ;
    endcase
    sendFrame(data, stop_bit);
  endtask

  task automatic waitNotEmpty(input string name, input int budget);
    int n;
    n = 0;
    while (empty_o && n < budget) begin
      tick(1);
      n++;
    end
    checkOutput(name, 32'(empty_o), 32'd0);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    rd_en_i = 1'b1;
    while (!empty_o && n < 64) begin
      tick(1);
      n++;
    end
    rd_en_i = 1'b0;
    checkOutput({name, "_empty"}, 32'(empty_o), 32'd1);
    checkOutput({name, "_pending"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic checkFlags(input string name);
    checkOutput({name, "_frame_err"}, 32'(frame_err_seen), 32'(exp_frame_err));
    checkOutput({name, "_overrun"}, 32'(overrun_seen), 32'(exp_overrun));
  endtask

  initial begin
    checks = 0;
    failures = 0;
    exp_frame_err = 0;
    exp_overrun = 0;
    frame_err_seen = 0;
    overrun_seen = 0;
    rst_ni = 1'b0;
    rx_en_i = 1'b1;
    rx_bit_i = 1'b1;
    rd_en_i = 1'b0;

    tick(5);
    checkOutput("reset_empty", 32'(empty_o), 32'd1);
    checkOutput("reset_full", 32'(full_o), 32'd0);
    checkOutput("reset_dout", 32'(dout_o), 32'd0);
    checkOutput("reset_frame_err", 32'(frame_err_o), 32'd0);
    checkOutput("reset_overrun", 32'(overrun_o), 32'd0);
    rst_ni = 1'b1;
    tick(10);

    $display("[TB] test 1: single byte 0xA5");
    applyStimulus(8'hA5, 1'b1, EXP_BYTE);
    waitNotEmpty("t1_wait", 4 * BIT_CLKS);
    checkOutput("t1_dout", 32'(dout_o), 32'h0000_00A5);
    drain("t1");
    checkFlags("t1");

    $display("[TB] test 2: false start");
    rx_bit_i = 1'b0;
    tick(BIT_CLKS / 4);
    rx_bit_i = 1'b1;
    tick(12 * BIT_CLKS);
    checkOutput("t2_empty", 32'(empty_o), 32'd1);
    checkFlags("t2");

    $display("[TB] test 3: framing error then good frame");
    applyStimulus(8'h3C, 1'b0, EXP_FRAME_ERR);
    tick(2 * BIT_CLKS);
    checkOutput("t3_empty_after_err", 32'(empty_o), 32'd1);
    checkFlags("t3_err");
    applyStimulus(8'h3C, 1'b1, EXP_BYTE);
    waitNotEmpty("t3_wait", 4 * BIT_CLKS);
    checkOutput("t3_dout", 32'(dout_o), 32'h0000_003C);
    drain("t3");
    checkFlags("t3");

    $display("[TB] test 4: fill FIFO and overrun");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(8'(i), 1'b1, EXP_BYTE);
    end
    checkOutput("t4_full", 32'(full_o), 32'd1);
    checkOutput("t4_head", 32'(dout_o), 32'd0);
    applyStimulus(8'h10, 1'b1, EXP_OVERRUN);
    tick(BIT_CLKS);
    checkOutput("t4_still_full", 32'(full_o), 32'd1);
    checkFlags("t4_overrun");
    drain("t4");
    checkOutput("t4_not_full", 32'(full_o), 32'd0);

    $display("[TB] test 5: abort on rx_en_i drop");
    rx_bit_i = 1'b0;
    tick(BIT_CLKS);
    rx_bit_i = 1'b1;
    tick(4 * BIT_CLKS + BIT_CLKS / 2);
    rx_en_i = 1'b0;
    tick(20);
    rx_en_i = 1'b1;
    tick(6 * BIT_CLKS);
    checkOutput("t5_empty_after_abort", 32'(empty_o), 32'd1);
    applyStimulus(8'h81, 1'b1, EXP_BYTE);
    waitNotEmpty("t5_wait", 4 * BIT_CLKS);
    checkOutput("t5_dout", 32'(dout_o), 32'h0000_0081);
    drain("t5");
    checkFlags("t5");

    $display("[TB] test 6: async reset mid-frame");
    applyStimulus(8'h11, 1'b1, EXP_NONE);
    applyStimulus(8'h22, 1'b1, EXP_NONE);
    applyStimulus(8'h33, 1'b1, EXP_NONE);
    checkOutput("t6_queued_head", 32'(dout_o), 32'h0000_0011);
    rx_bit_i = 1'b0;
    tick(BIT_CLKS);
    tick(2 * BIT_CLKS + BIT_CLKS / 2);
    rst_ni = 1'b0;
    #1;
    checkOutput("t6_rst_empty", 32'(empty_o), 32'd1);
    checkOutput("t6_rst_full", 32'(full_o), 32'd0);
    checkOutput("t6_rst_dout", 32'(dout_o), 32'd0);
    checkOutput("t6_rst_frame_err", 32'(frame_err_o), 32'd0);
    checkOutput("t6_rst_overrun", 32'(overrun_o), 32'd0);
    rx_bit_i = 1'b1;
    tick(3);
    rst_ni = 1'b1;
    tick(2 * BIT_CLKS);
    applyStimulus(8'h55, 1'b1, EXP_BYTE);
    waitNotEmpty("t6_wait", 4 * BIT_CLKS);
    checkOutput("t6_dout", 32'(dout_o), 32'h0000_0055);
    drain("t6");
    checkFlags("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
